if2_fetch_ctrl: RTL and testbench



---
 rtl/if2_fetch_ctrl_pkg.sv | 14 +
 rtl/if2_fetch_ctrl_sat_cnt16.sv | 18 +
 rtl/if2_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_if2_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if2_fetch_ctrl_pkg.sv
// Shared definitions for the IF2 fetch-stage controller: state encodings and
// the bubble instruction word.
package if2_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IF2_IDLE  = 2'd0,
    IF2_WAIT  = 2'd1,
    IF2_HAVE  = 2'd2,
    IF2_DRAIN = 2'd3
  } if2_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/if2_fetch_ctrl_sat_cnt16.sv
// 16-bit saturating event counter with enable; sticks at all-ones and only
// clears on reset, so it can be reused for other performance counters.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/if2_fetch_ctrl.sv
// IF2 fetch-stage controller: holds the accepted PC, waits for the I-cache
// response, buffers it while decode stalls and discards responses killed by flush.
module if2_fetch_ctrl
  import if2_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if1_valid,
  input  logic [31:0] if1_pc,
  input  logic        if1_branch_bp,
  input  logic        icache_rvalid,
  input  logic        icache_hit,
  input  logic [31:0] icache_rdata,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if2_ready,
  output logic [31:0] if2_pc,
  output logic [31:0] if2_inst,
  output logic        if2_icache_hit,
  output logic        if2_branch_bp,
  output logic        if1_if2_cache_valid,
  output logic [15:0] if2_wait_cycles
);

  if2_state_e  state_q, state_d;
  logic [31:0] pc_q, inst_q;
  logic        hit_q, bp_q;
  logic        valid, transfer, accept, capture, wait_en;

  // Handshake terms; flush kills both the outgoing instruction and acceptance.
  always_comb begin
    valid    = !flush && ((state_q == IF2_HAVE) ||
                          ((state_q == IF2_WAIT) && icache_rvalid));
    transfer = valid && !id_stall;
    if2_ready = !flush && ((state_q == IF2_IDLE) || transfer);
    accept   = if1_valid && if2_ready;
    capture  = !flush && (state_q == IF2_WAIT) && icache_rvalid && id_stall;
    wait_en  = ((state_q == IF2_WAIT) || (state_q == IF2_DRAIN)) && !icache_rvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF2_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stray responses in IDLE/HAVE are protocol errors and leave state untouched.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      case (state_q)
        IF2_WAIT:  state_d = icache_rvalid ? IF2_IDLE : IF2_DRAIN;
        IF2_DRAIN: state_d = icache_rvalid ? IF2_IDLE : IF2_DRAIN;
        default:   state_d = IF2_IDLE;
      endcase
    end else begin
      case (state_q)
        IF2_IDLE: begin
          if (accept) state_d = IF2_WAIT;
        end
        IF2_WAIT: begin
          if (icache_rvalid) begin
            if (id_stall)    state_d = IF2_HAVE;
            else if (accept) state_d = IF2_WAIT;
            else             state_d = IF2_IDLE;
          end
        end
        IF2_HAVE: begin
          if (!id_stall) state_d = accept ? IF2_WAIT : IF2_IDLE;
        end
        IF2_DRAIN: begin
          if (icache_rvalid) state_d = IF2_IDLE;
        end
        default: state_d = IF2_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= 32'h0;
      bp_q   <= 1'b0;
      inst_q <= INST_NOP;
      hit_q  <= 1'b0;
    end else begin
      if (accept) begin
        pc_q <= if1_pc;
        bp_q <= if1_branch_bp;
      end
      if (capture) begin
        inst_q <= icache_rdata;
        hit_q  <= icache_hit;
      end
    end
  end

  // Payload muxes: buffered copy in HAVE, live cache data in WAIT, bubble otherwise.
  always_comb begin
    if2_inst       = INST_NOP;
    if2_icache_hit = 1'b0;
    if (valid) begin
      if (state_q == IF2_HAVE) begin
        if2_inst       = inst_q;
        if2_icache_hit = hit_q;
      end else begin
        if2_inst       = icache_rdata;
        if2_icache_hit = icache_hit;
      end
    end
  end

  assign if2_pc              = pc_q;
  assign if2_branch_bp       = bp_q;
  assign if1_if2_cache_valid = valid;

  sat_cnt16 u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wait_en),
    .count (if2_wait_cycles)
  );

endmodule

// File: tb/tb_if2_fetch_ctrl.sv
// Directed self-checking bench for if2_fetch_ctrl: hit stream, miss, stall,
// flush cases, async reset and wait-counter saturation.
module tb_if2_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic        if1_branch_bp;
  logic        icache_rvalid;
  logic        icache_hit;
  logic [31:0] icache_rdata;
  logic        id_stall;
  logic        flush;
  logic        if2_ready;
  logic [31:0] if2_pc;
  logic [31:0] if2_inst;
  logic        if2_icache_hit;
  logic        if2_branch_bp;
  logic        if1_if2_cache_valid;
  logic [15:0] if2_wait_cycles;

  int total  = 0;
  int passed = 0;

  if2_fetch_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if1_valid           (if1_valid),
    .if1_pc              (if1_pc),
    .if1_branch_bp       (if1_branch_bp),
    .icache_rvalid       (icache_rvalid),
    .icache_hit          (icache_hit),
    .icache_rdata        (icache_rdata),
    .id_stall            (id_stall),
    .flush               (flush),
    .if2_ready           (if2_ready),
    .if2_pc              (if2_pc),
    .if2_inst            (if2_inst),
    .if2_icache_hit      (if2_icache_hit),
    .if2_branch_bp       (if2_branch_bp),
    .if1_if2_cache_valid (if1_if2_cache_valid),
    .if2_wait_cycles     (if2_wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    if1_valid = 0; if1_pc = 32'h0; if1_branch_bp = 0;
    icache_rvalid = 0; icache_hit = 0; icache_rdata = 32'h0;
    id_stall = 0; flush = 0;
    #2 rst_n = 1'b0;
    #2;
    check_output("rst_ready", if2_ready, 1);
    check_output("rst_valid", if1_if2_cache_valid, 0);
    check_output("rst_pc", if2_pc, 32'h0);
    check_output("rst_inst", if2_inst, 32'h0);
    check_output("rst_hit", if2_icache_hit, 0);
    check_output("rst_bp", if2_branch_bp, 0);
    check_output("rst_cnt", if2_wait_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Hit stream: three PCs, each answered the following cycle
    if1_valid = 1; if1_pc = 32'h1C00_0000; if1_branch_bp = 0;
    #1 check_output("hs0_ready", if2_ready, 1);
    cyc();
    if1_pc = 32'h1C00_0004; if1_branch_bp = 1;
    icache_rvalid = 1; icache_hit = 1; icache_rdata = 32'h0010_0093;
    #1;
    check_output("hs1_valid", if1_if2_cache_valid, 1);
    check_output("hs1_pc", if2_pc, 32'h1C00_0000);
    check_output("hs1_inst", if2_inst, 32'h0010_0093);
    check_output("hs1_hit", if2_icache_hit, 1);
    check_output("hs1_ready", if2_ready, 1);
    cyc();
    if1_pc = 32'h1C00_0008; if1_branch_bp = 0; icache_rdata = 32'h0020_0113;
    #1;
    check_output("hs2_valid", if1_if2_cache_valid, 1);
    check_output("hs2_pc", if2_pc, 32'h1C00_0004);
    check_output("hs2_inst", if2_inst, 32'h0020_0113);
    check_output("hs2_bp", if2_branch_bp, 1);
    check_output("hs2_ready", if2_ready, 1);
    cyc();
    if1_valid = 0; icache_rdata = 32'h0030_0193;
    #1;
    check_output("hs3_valid", if1_if2_cache_valid, 1);
    check_output("hs3_pc", if2_pc, 32'h1C00_0008);
    check_output("hs3_inst", if2_inst, 32'h0030_0193);
    check_output("hs3_ready", if2_ready, 1);
    cyc();
    icache_rvalid = 0; icache_hit = 0; icache_rdata = 32'h0;

    // Miss: five empty WAIT cycles before the response
    if1_valid = 1; if1_pc = 32'h1C00_0010;
    #1;
    check_output("idle_valid", if1_if2_cache_valid, 0);
    check_output("idle_ready", if2_ready, 1);
    cyc();
    if1_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("miss_ready", if2_ready, 0);
      check_output("miss_valid", if1_if2_cache_valid, 0);
      cyc();
    end
    icache_rvalid = 1; icache_hit = 0; icache_rdata = 32'h0280_0421;
    #1;
    check_output("miss_rvalid", if1_if2_cache_valid, 1);
    check_output("miss_hit", if2_icache_hit, 0);
    check_output("miss_inst", if2_inst, 32'h0280_0421);
    check_output("miss_pc", if2_pc, 32'h1C00_0010);
    check_output("miss_cnt", if2_wait_cycles, 16'd5);
    cyc();
    icache_rvalid = 0; icache_rdata = 32'h0;
    #1;
    check_output("miss_done_valid", if1_if2_cache_valid, 0);
    check_output("miss_done_cnt", if2_wait_cycles, 16'd5);

    // Stall: response arrives with decode stalled for three cycles
    if1_valid = 1; if1_pc = 32'h1C00_0020;
    cyc();
    if1_valid = 0;
    icache_rvalid = 1; icache_hit = 1; icache_rdata = 32'h0015_0004; id_stall = 1;
    #1;
    check_output("st0_valid", if1_if2_cache_valid, 1);
    check_output("st0_ready", if2_ready, 0);
    cyc();
    icache_rvalid = 0; icache_hit = 0; icache_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_output("st_hold_valid", if1_if2_cache_valid, 1);
      check_output("st_hold_inst", if2_inst, 32'h0015_0004);
      check_output("st_hold_hit", if2_icache_hit, 1);
      check_output("st_hold_ready", if2_ready, 0);
      cyc();
    end
    id_stall = 0;
    #1;
    check_output("st_xfer_valid", if1_if2_cache_valid, 1);
    check_output("st_xfer_inst", if2_inst, 32'h0015_0004);
    check_output("st_xfer_pc", if2_pc, 32'h1C00_0020);
    check_output("st_xfer_ready", if2_ready, 1);
    cyc();
    check_output("st_after_valid", if1_if2_cache_valid, 0);
    check_output("st_after_cnt", if2_wait_cycles, 16'd5);

    // Flush in WAIT without response: DRAIN until the late response
    if1_valid = 1; if1_pc = 32'h1C00_0030;
    cyc();
    if1_pc = 32'h1C00_0999; flush = 1;
    #1;
    check_output("fw_ready", if2_ready, 0);
    check_output("fw_valid", if1_if2_cache_valid, 0);
    cyc();
    flush = 0;
    #1;
    check_output("dr1_ready", if2_ready, 0);
    check_output("dr1_valid", if1_if2_cache_valid, 0);
    cyc();
    icache_rvalid = 1; icache_hit = 1; icache_rdata = 32'hDEAD_BEEF;
    #1;
    check_output("dr2_valid", if1_if2_cache_valid, 0);
    check_output("dr2_inst", if2_inst, 32'h0);
    check_output("dr2_ready", if2_ready, 0);
    cyc();
    if1_valid = 0; icache_rvalid = 0; icache_hit = 0; icache_rdata = 32'h0;
    #1;
    check_output("dr_idle_ready", if2_ready, 1);
    check_output("dr_pc_kept", if2_pc, 32'h1C00_0030);
    check_output("dr_cnt", if2_wait_cycles, 16'd7);

    // Flush coincident with a response in WAIT
    if1_valid = 1; if1_pc = 32'h1C00_0040;
    cyc();
    if1_valid = 0; icache_rvalid = 1; icache_rdata = 32'h1111_1111; flush = 1;
    #1;
    check_output("fr_valid", if1_if2_cache_valid, 0);
    check_output("fr_ready", if2_ready, 0);
    cyc();
    icache_rvalid = 0; icache_rdata = 32'h0; flush = 0;
    #1;
    check_output("fr_next_ready", if2_ready, 1);
    check_output("fr_next_valid", if1_if2_cache_valid, 0);

    // Flush while holding an instruction in HAVE
    if1_valid = 1; if1_pc = 32'h1C00_0050;
    cyc();
    if1_valid = 0; icache_rvalid = 1; icache_rdata = 32'h2222_2222; id_stall = 1;
    cyc();
    icache_rvalid = 0; icache_rdata = 32'h0; flush = 1;
    #1;
    check_output("fh_valid", if1_if2_cache_valid, 0);
    check_output("fh_ready", if2_ready, 0);
    cyc();
    flush = 0; id_stall = 0;
    #1;
    check_output("fh_next_ready", if2_ready, 1);
    check_output("fh_next_valid", if1_if2_cache_valid, 0);

    // Stray response in IDLE is ignored
    icache_rvalid = 1; icache_rdata = 32'h3333_3333;
    #1;
    check_output("stray_valid", if1_if2_cache_valid, 0);
    check_output("stray_ready", if2_ready, 1);
    cyc();
    icache_rvalid = 0; icache_rdata = 32'h0;
    #1;
    check_output("stray_idle_ready", if2_ready, 1);
    check_output("stray_cnt", if2_wait_cycles, 16'd7);

    // Async reset mid-WAIT, then a late response after release
    if1_valid = 1; if1_pc = 32'h1C00_0060; if1_branch_bp = 1;
    cyc();
    if1_valid = 0; if1_branch_bp = 0;
    #1;
    check_output("ar_pre_pc", if2_pc, 32'h1C00_0060);
    check_output("ar_pre_bp", if2_branch_bp, 1);
    check_output("ar_pre_ready", if2_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check_output("ar_ready", if2_ready, 1);
    check_output("ar_pc", if2_pc, 32'h0);
    check_output("ar_bp", if2_branch_bp, 0);
    check_output("ar_cnt", if2_wait_cycles, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    icache_rvalid = 1; icache_rdata = 32'h4444_4444;
    #1;
    check_output("ar_late_valid", if1_if2_cache_valid, 0);
    check_output("ar_late_ready", if2_ready, 1);
    cyc();
    icache_rvalid = 0; icache_rdata = 32'h0;
    #1;
    check_output("ar_after_ready", if2_ready, 1);

    // Counter saturation: 70000 empty WAIT cycles
    if1_valid = 1; if1_pc = 32'h1C00_0070;
    cyc();
    if1_valid = 0;
    repeat (65534) @(posedge clk);
    #1;
    check_output("sat_pre", if2_wait_cycles, 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    check_output("sat_full", if2_wait_cycles, 16'hFFFF);
    icache_rvalid = 1; icache_rdata = 32'h5555_5555;
    #1;
    check_output("sat_resp_valid", if1_if2_cache_valid, 1);
    cyc();
    icache_rvalid = 0;
    #1;
    check_output("sat_hold", if2_wait_cycles, 16'hFFFF);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
